// File: rtl/lsu_data_port.sv
// Load/store data port: aligns stores onto byte lanes, extends loads,
// and stalls the pipeline while a memory transaction is in flight.
module lsu_data_port #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Stall,
  output logic              MisalignErr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] WAIT_R = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              op;
  logic              legal;
  logic [1:0]        off;
  logic [3:0]        be_c;
  logic [DATA_W-1:0] wd_c;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [DATA_W-1:0] rsh;
  logic [DATA_W-1:0] ld_ext;

  assign op  = MemRead | MemWrite;
  assign off = ALUResult[1:0];

  always_comb begin
    legal = 1'b1;
    if (MemRead && MemWrite) begin
      legal = 1'b0;
    end else if (MemRead) begin
      case (funct3)
        3'b000, 3'b001, 3'b010,
        3'b100, 3'b101: legal = 1'b1;
        default:        legal = 1'b0;
      endcase
    end else if (MemWrite) begin
      legal = (funct3 <= 3'b010);
    end
    if (funct3[1:0] == 2'b01 && off[0])
      legal = 1'b0;
    if (funct3[1:0] == 2'b10 && off != 2'b00)
      legal = 1'b0;
  end

  always_comb begin
    be_c = 4'b1111;
    wd_c = WriteData;
    case (funct3[1:0])
      2'b00: begin
        be_c = 4'b0001 << off;
        wd_c = {4{WriteData[7:0]}};
      end
      2'b01: begin
        be_c = 4'b0011 << off;
        wd_c = {2{WriteData[15:0]}};
      end
      default: begin
        be_c = 4'b1111;
        wd_c = WriteData;
      end
    endcase
  end

  // byte/halfword of interest is shifted down to bit 0 first
  assign rsh = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  ld_ext = {{24{rsh[7]}}, rsh[7:0]};
      3'b001:  ld_ext = {{16{rsh[15]}}, rsh[15:0]};
      3'b100:  ld_ext = {24'd0, rsh[7:0]};
      3'b101:  ld_ext = {16'd0, rsh[15:0]};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (op && legal) state_nxt = REQ;
      REQ:     if (mem_gnt) state_nxt = mem_we ? DONE : WAIT_R;
      WAIT_R:  if (mem_rvalid) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign Stall = (state == IDLE && op && legal)
               | (state == REQ)
               | (state == WAIT_R);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= 4'b0000;
      mem_wdata   <= '0;
      ReadData    <= '0;
      MisalignErr <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
    end else begin
      state       <= state_nxt;
      MisalignErr <= (state == IDLE) && op && !legal;
      if (state == IDLE && op && legal) begin
        mem_req   <= 1'b1;
        mem_we    <= MemWrite;
        mem_addr  <= {ALUResult[ADDR_W-1:2], 2'b00};
        mem_be    <= be_c;
        mem_wdata <= wd_c;
        f3_q      <= funct3;
        off_q     <= off;
      end else if (state == REQ && mem_gnt) begin
        mem_req <= 1'b0;
      end
      if (state == WAIT_R && mem_rvalid)
        ReadData <= ld_ext;
    end
  end

endmodule
